// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and word-select helper for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned TAG_W      = 3;
  localparam int unsigned INDEX_W    = 3;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = TAG_W + INDEX_W + OFFSET_W + 2;
  localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE     = 2'd0;
  localparam state_t S_MEM_READ = 2'd1;
  localparam state_t S_UPDATE   = 2'd2;

  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0]  blk,
                                                    input logic [OFFSET_W-1:0] off);
    return blk[{off, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 8 blocks x 16 bytes, zero-cycle hits.
// Optional HIT_COUNT/MISS_COUNT statistics outputs are enabled by defining ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_W-1:0]     ADDRESS,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic                unused_addr_bits;

  assign tag              = ADDRESS[9:7];
  assign index            = ADDRESS[6:4];
  assign offset           = ADDRESS[3:2];
  assign unused_addr_bits = ^ADDRESS[1:0];

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    fill_q;
  state_t                state_q, state_d;
  logic                  hit;

  assign hit = valid_q[index] && (tag_q[index] == tag);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (!hit) state_d = S_MEM_READ;
      S_MEM_READ: if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      S_UPDATE:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_UPDATE) valid_q[index] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; valid_q alone decides whether an entry is usable.
  always_ff @(posedge CLK) begin
    if (state_q == S_MEM_READ && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
    if (state_q == S_UPDATE) begin
      tag_q[index]  <= tag;
      data_q[index] <= fill_q;
    end
  end

  // RESET masks every output so the cpu sees a quiet cache while reset is held.
  always_comb begin
    INSTRUCTION = '0;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    if (!RESET) begin
      case (state_q)
        S_IDLE: begin
          if (hit) INSTRUCTION = select_word(data_q[index], offset);
          else     BUSYWAIT    = 1'b1;
        end
        S_MEM_READ: begin
          BUSYWAIT    = 1'b1;
          MEM_READ    = 1'b1;
          MEM_ADDRESS = {tag, index};
        end
        default: BUSYWAIT = 1'b1;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (hit && hit_count_q != 16'hFFFF)    hit_count_q  <= hit_count_q + 16'd1;
      if (!hit && miss_count_q != 16'hFFFF)  miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: randomized fetches against a block-level cache model.
module tb_icache;

  logic         CLK;
  logic         RESET;
  logic [9:0]   ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  icache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (hit_count),
    .MISS_COUNT   (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Backing instruction memory and cache model: which block (by tag) each line holds.
  logic [127:0] mem [64];
  bit           ref_valid [8];
  bit [2:0]     ref_tag   [8];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit model_hit(input logic [9:0] a);
    return ref_valid[a[6:4]] && ref_tag[a[6:4]] == a[9:7];
  endfunction

  function automatic logic [31:0] model_word(input logic [9:0] a);
    logic [127:0] b;
    int w;
    b = mem[a[9:4]];
    w = a[3:2];
    return b[w*32 +: 32];
  endfunction

  task automatic model_fill(input logic [9:0] a);
    ref_valid[a[6:4]] = 1'b1;
    ref_tag[a[6:4]]   = a[9:7];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  // Presents one fetch (entered at posedge+1), acts as the memory, returns what was observed.
  // Memory drops MEM_BUSYWAIT on the wait_n-th cycle of a read request.
  task automatic access(input logic [9:0] addr, input int wait_n, output int busy,
                        output logic [31:0] instr, output logic saw_rd,
                        output logic [5:0] rd_addr, output logic quiet_ok,
                        output logic timed_out);
    int rd_cnt;
    ADDRESS = addr; busy = 0; instr = '0; saw_rd = 0; rd_addr = '0;
    quiet_ok = 1; timed_out = 1; rd_cnt = 0;
    for (int c = 0; c < 100 && timed_out; c++) begin
      #2;
      if (!MEM_READ && MEM_ADDRESS !== 6'd0) quiet_ok = 0;
      if (BUSYWAIT === 1'b0) begin
        instr = INSTRUCTION;
        timed_out = 0;
        if (MEM_READ !== 1'b0) quiet_ok = 0;
      end else begin
        busy++;
        if (INSTRUCTION !== 32'h0) quiet_ok = 0;
        if (MEM_READ === 1'b1) begin
          if (!saw_rd) rd_addr = MEM_ADDRESS;
          saw_rd = 1;
          rd_cnt++;
          if (rd_cnt >= wait_n) begin
            MEM_BUSYWAIT = 1'b0;
            MEM_READDATA = mem[MEM_ADDRESS];
          end else begin
            MEM_BUSYWAIT = 1'b1;
            MEM_READDATA = rand128();
          end
        end else begin
          MEM_BUSYWAIT = 1'b1;
          MEM_READDATA = rand128();
        end
      end
      @(posedge CLK); #1;
    end
    MEM_BUSYWAIT = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ADDRESS = 10'($urandom);
    @(posedge CLK); #1; @(posedge CLK); #3;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b exp=0", MEM_READ); end
    total++; if (MEM_ADDRESS !== 6'd0) begin bad++; $display("FAIL reset_mem_address got=%h exp=0", MEM_ADDRESS); end
    total++; if (INSTRUCTION !== 32'h0) begin bad++; $display("FAIL reset_instruction got=%h exp=0", INSTRUCTION); end
    @(posedge CLK); #1;
    model_clear();
  endtask

  task automatic test_first_fill();
    int busy; logic [31:0] instr; logic rd, q, to; logic [5:0] ra;
    RESET = 1'b0;
    access(10'h000, 5, busy, instr, rd, ra, q, to);
    model_fill(10'h000);
    total++; if (busy !== 7) begin bad++; $display("FAIL fill_busy_cycles got=%0d exp=7", busy); end
    total++; if (instr !== 32'h0000_0000) begin bad++; $display("FAIL fill_word0 got=%h exp=0", instr); end
    total++; if (rd !== 1'b1 || ra !== 6'd0) begin bad++; $display("FAIL fill_request got=%b/%h exp=1/00", rd, ra); end
    total++; if (q !== 1'b1) begin bad++; $display("FAIL fill_quiet_outputs got=%b exp=1", q); end
    total++; if (to !== 1'b0) begin bad++; $display("FAIL fill_timeout got=%b exp=0", to); end
  endtask

  task automatic test_hits();
    int busy; logic [31:0] instr; logic rd, q, to; logic [5:0] ra;
    for (int k = 1; k < 4; k++) begin
      access(10'(k * 4), 3, busy, instr, rd, ra, q, to);
      total++; if (busy !== 0 || to) begin bad++; $display("FAIL hit%0d_busy got=%0d exp=0", k, busy); end
      total++; if (instr !== 32'(k)) begin bad++; $display("FAIL hit%0d_word got=%h exp=%h", k, instr, 32'(k)); end
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL hit%0d_mem_read got=%b exp=0", k, rd); end
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL stats_miss got=%0d exp=1", miss_count); end
    total++; if (hit_count !== 16'd4) begin bad++; $display("FAIL stats_hit got=%0d exp=4", hit_count); end
  endtask
`endif

  // Table/random driven fetches, every result predicted from the cache model.
  task automatic run_seq(input string tag_name, input logic [9:0] addrs[$], input int waits[$]);
    int busy; logic [31:0] instr; logic rd, q, to; logic [5:0] ra; bit eh; int eb;
    foreach (addrs[i]) begin
      eh = model_hit(addrs[i]);
      eb = eh ? 0 : waits[i] + 2;
      access(addrs[i], waits[i], busy, instr, rd, ra, q, to);
      model_fill(addrs[i]);
      total++; if (busy !== eb || to) begin bad++; $display("FAIL %s[%0d]_busy addr=%h got=%0d exp=%0d", tag_name, i, addrs[i], busy, eb); end
      total++; if (instr !== model_word(addrs[i])) begin bad++; $display("FAIL %s[%0d]_word addr=%h got=%h exp=%h", tag_name, i, addrs[i], instr, model_word(addrs[i])); end
      total++; if (rd !== !eh || (!eh && ra !== addrs[i][9:4])) begin bad++; $display("FAIL %s[%0d]_request addr=%h got=%b/%h exp=%b/%h", tag_name, i, addrs[i], rd, ra, !eh, addrs[i][9:4]); end
      total++; if (q !== 1'b1) begin bad++; $display("FAIL %s[%0d]_quiet got=%b exp=1", tag_name, i, q); end
    end
  endtask

  task automatic test_conflict();
    int busy; logic [31:0] instr; logic rd, q, to; logic [5:0] ra;
    access(10'h080, 2, busy, instr, rd, ra, q, to);
    model_fill(10'h080);
    total++; if (ra !== 6'b001000 || rd !== 1'b1) begin bad++; $display("FAIL conflict_mem_address got=%b exp=001000", ra); end
    total++; if (busy !== 4 || instr !== model_word(10'h080)) begin bad++; $display("FAIL conflict_fill got=%0d/%h exp=4/%h", busy, instr, model_word(10'h080)); end
    access(10'h000, 3, busy, instr, rd, ra, q, to);
    model_fill(10'h000);
    total++; if (busy !== 5 || instr !== 32'h0) begin bad++; $display("FAIL conflict_refetch got=%0d/%h exp=5/0", busy, instr); end
  endtask

  task automatic test_wrap_and_fast();
    logic [9:0] a[$]; int w[$];
    a = '{10'h070, 10'h100, 10'h074, 10'h10C, 10'h300, 10'h070};
    w = '{1, 1, 1, 1, 4, 2};
    run_seq("wrap", a, w);
  endtask

  task automatic test_reset_mid_miss();
    int busy; logic [31:0] instr; logic rd, q, to; logic [5:0] ra;
    ADDRESS = 10'h1A4; MEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #2;
    total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL abort_setup_mem_read got=%b exp=1", MEM_READ); end
    RESET = 1'b1; #1;
    total++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin bad++; $display("FAIL abort_drop got=%b/%b exp=0/0", MEM_READ, BUSYWAIT); end
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = rand128();
    @(posedge CLK); #1; @(posedge CLK); #1;
    MEM_BUSYWAIT = 1'b1; RESET = 1'b0;
    model_clear();
    access(10'h1A4, 2, busy, instr, rd, ra, q, to);
    model_fill(10'h1A4);
    total++; if (busy !== 4 || instr !== model_word(10'h1A4)) begin bad++; $display("FAIL abort_refetch got=%0d/%h exp=4/%h", busy, instr, model_word(10'h1A4)); end
    access(10'h004, 1, busy, instr, rd, ra, q, to);
    model_fill(10'h004);
    total++; if (busy !== 3 || instr !== 32'h1) begin bad++; $display("FAIL post_reset_miss got=%0d/%h exp=3/1", busy, instr); end
  endtask

  task automatic test_random();
    logic [9:0] a[$]; int w[$];
    for (int i = 0; i < 60; i++) begin
      a.push_back({1'b0, 2'($urandom), 3'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)});
      w.push_back(int'($urandom_range(1, 4)));
    end
    run_seq("rand", a, w);
  endtask

  initial begin
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    for (int i = 0; i < 64; i++) mem[i] = rand128();
    mem[0] = {32'h3, 32'h2, 32'h1, 32'h0};
    test_reset();
    test_first_fill();
    test_hits();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    test_conflict();
    test_wrap_and_fast();
    test_reset_mid_miss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
